// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a single-outstanding imem request
// and fills the IF/ID register, with EX redirect and hazard stall handling.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t          state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic [XLEN-1:0] req_pc, req_pc_d;
    logic [XLEN-1:0] hold_pc, hold_pc_d;
    logic [XLEN-1:0] hold_instr, hold_instr_d;
    logic [XLEN-1:0] id_pc_d, id_instr_d;
    logic            id_valid_d;
    logic            can_load;

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;
    assign can_load       = !stall || !if_id_valid;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            pc                <= RESET_PC;
            req_pc            <= '0;
            hold_pc           <= '0;
            hold_instr        <= '0;
            if_id_pc          <= '0;
            if_id_instruction <= '0;
            if_id_valid       <= 1'b0;
        end else begin
            state             <= state_d;
            pc                <= pc_d;
            req_pc            <= req_pc_d;
            hold_pc           <= hold_pc_d;
            hold_instr        <= hold_instr_d;
            if_id_pc          <= id_pc_d;
            if_id_instruction <= id_instr_d;
            if_id_valid       <= id_valid_d;
        end
    end

    // Next-state and datapath; a redirect overrides everything computed first
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        req_pc_d     = req_pc;
        hold_pc_d    = hold_pc;
        hold_instr_d = hold_instr;
        id_pc_d      = if_id_pc;
        id_instr_d   = if_id_instruction;
        id_valid_d   = stall && if_id_valid;

        case (state)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_ready) begin
                    req_pc_d = pc;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    pc_d = req_pc + PC_STEP;
                    if (can_load) begin
                        id_pc_d    = req_pc;
                        id_instr_d = imem_resp_data;
                        id_valid_d = 1'b1;
                        state_d    = S_REQ;
                    end else begin
                        hold_pc_d    = req_pc;
                        hold_instr_d = imem_resp_data;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    id_pc_d    = hold_pc;
                    id_instr_d = hold_instr;
                    id_valid_d = 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (branch_taken) begin
            id_valid_d   = 1'b0;
            hold_pc_d    = '0;
            hold_instr_d = '0;
            pc_d         = branch_target & ALIGN_MASK;
            case (state)
                S_IDLE:  state_d = S_REQ;
                S_REQ:   state_d = imem_req_ready ? S_DRAIN : S_REQ;
                S_WAIT:  state_d = imem_resp_valid ? S_REQ : S_DRAIN;
                S_HOLD:  state_d = S_REQ;
                S_DRAIN: state_d = imem_resp_valid ? S_REQ : S_DRAIN;
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule
